// File: rtl/ctech_lib_and_tree_pkg.sv
// Shared helpers for the pipelined AND-reduction cell: tree sizing
// functions, legal parameter ranges and a parameter legality check.
`timescale 1ns/1ps
package ctech_lib_and_tree_pkg;

    localparam int N_IN_MIN  = 2;
    localparam int N_IN_MAX  = 16;
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;
    localparam int LVLS_MIN  = 1;
    localparam int LVLS_MAX  = 4;

    // ceil(log2(n)): number of 2-input AND levels in a balanced tree.
    function automatic int tree_depth(input int n);
        int d = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << d) < n) d++;
        end
        return d;
    endfunction

    // Number of register stages when each stage covers lvls tree levels.
    function automatic int num_stages(input int n, input int lvls);
        return (tree_depth(n) + lvls - 1) / lvls;
    endfunction

    // Operands remaining after s stages: ceil(n / 2^(lvls*s)).
    function automatic int ops_after(input int n, input int lvls, input int s);
        int sh = lvls * s;
        if (sh >= 30) return 1;
        return (n + (1 << sh) - 1) >> sh;
    endfunction

    // True when every parameter lies in its supported range.
    function automatic bit params_ok(input int n, input int w, input int lvls, input int inv);
        return (n >= N_IN_MIN) && (n <= N_IN_MAX) &&
               (w >= WIDTH_MIN) && (w <= WIDTH_MAX) &&
               (lvls >= LVLS_MIN) && (lvls <= LVLS_MAX) &&
               ((inv == 0) || (inv == 1));
    endfunction

endpackage

// File: rtl/ctech_lib_and_tree_stage.sv
// One registered stage of the AND tree: M_IN operands are reduced in
// groups of 2^LVLS to M_OUT operands, optionally inverted, then
// registered together with a valid bit. adv=0 holds both registers.
`timescale 1ns/1ps
module ctech_lib_and_tree_stage
    import ctech_lib_and_tree_pkg::*;
#(
    parameter int M_IN   = 2,
    parameter int WIDTH  = 1,
    parameter int LVLS   = 1,
    parameter int INVERT = 0,
    localparam int M_OUT = ops_after(M_IN, LVLS, 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     adv,
    input  logic                     v_in,
    input  logic [M_IN*WIDTH-1:0]    d_in,
    output logic                     v_out,
    output logic [M_OUT*WIDTH-1:0]   d_out
);

    localparam int GRP = 1 << LVLS;

    logic [M_OUT*WIDTH-1:0] red;

    // Operand index beyond the last real operand maps back onto the last
    // one; AND is idempotent, so re-using it equals the all-ones pass-through
    // of an odd operand in a balanced tree.
    function automatic int src_idx(input int n);
        return (n < M_IN) ? n : M_IN - 1;
    endfunction

    // Group-wise AND reduction, inverted in front of the register when asked.
    always_comb begin
        red = '1;
        for (int k = 0; k < M_OUT; k++) begin
            for (int i = 0; i < GRP; i++) begin
                red[k*WIDTH +: WIDTH] = red[k*WIDTH +: WIDTH] &
                                        d_in[src_idx(k*GRP + i)*WIDTH +: WIDTH];
            end
        end
        if (INVERT != 0) red = ~red;
    end

    // Stage registers: data loads on every advancing cycle regardless of valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_out <= 1'b0;
            d_out <= '0;
        end else if (adv) begin
            v_out <= v_in;
            d_out <= red;
        end
    end

endmodule

// File: rtl/ctech_lib_and_tree_pipe.sv
// Pipelined N_IN x WIDTH AND (optionally NAND) reduction with a valid bit
// travelling alongside the data. Latency = num_stages(N_IN, LVLS_PER_STAGE).
// Optional feature macro: CTECH_LIB_AND_TREE_STALL_EN adds a stall input
// that freezes every stage register and blocks input sampling.
// Handshake: a sample is taken on each advancing rising edge; in_valid marks
// it meaningful. out_valid marks o meaningful. There is no ready signal; with
// stall, upstream keeps its sample steady until stall drops.
`timescale 1ns/1ps
module ctech_lib_and_tree_pipe
    import ctech_lib_and_tree_pkg::*;
#(
    parameter int N_IN           = 4,
    parameter int WIDTH          = 1,
    parameter int LVLS_PER_STAGE = 1,
    parameter int INVERT         = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [N_IN*WIDTH-1:0]  a,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       o
`ifdef CTECH_LIB_AND_TREE_STALL_EN
    ,
    input  logic                   stall
`endif
);

    localparam int S = num_stages(N_IN, LVLS_PER_STAGE);

    if (!params_ok(N_IN, WIDTH, LVLS_PER_STAGE, INVERT)) begin : g_param_check
        $fatal(1, "ctech_lib_and_tree_pipe: illegal parameters N_IN=%0d WIDTH=%0d LVLS_PER_STAGE=%0d INVERT=%0d",
               N_IN, WIDTH, LVLS_PER_STAGE, INVERT);
    end

    logic adv;

`ifdef CTECH_LIB_AND_TREE_STALL_EN
    assign adv = ~stall;
`else
    assign adv = 1'b1;
`endif

    for (genvar s = 0; s < S; s++) begin : g_stg
        localparam int M_IN  = ops_after(N_IN, LVLS_PER_STAGE, s);
        localparam int M_OUT = ops_after(N_IN, LVLS_PER_STAGE, s + 1);

        logic [M_IN*WIDTH-1:0]  d_in;
        logic                   v_in;
        logic [M_OUT*WIDTH-1:0] d_q;
        logic                   v_q;

        if (s == 0) begin : g_first
            assign d_in = a;
            assign v_in = in_valid;
        end else begin : g_next
            assign d_in = g_stg[s-1].d_q;
            assign v_in = g_stg[s-1].v_q;
        end

        ctech_lib_and_tree_stage #(
            .M_IN   (M_IN),
            .WIDTH  (WIDTH),
            .LVLS   (LVLS_PER_STAGE),
            .INVERT ((s == S - 1) ? INVERT : 0)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .adv   (adv),
            .v_in  (v_in),
            .d_in  (d_in),
            .v_out (v_q),
            .d_out (d_q)
        );
    end

    assign o         = g_stg[S-1].d_q;
    assign out_valid = g_stg[S-1].v_q;

endmodule

// File: doc/ctech_lib_and_tree_pipe.md
# ctech_lib_and_tree_pipe

Parametrised, pipelined AND-reduction cell for the ctech library. It reduces N_IN input vectors of WIDTH bits to one WIDTH-bit result, with optional output inversion (NAND) and a configurable number of logic levels per register stage. A valid bit travels alongside the data. It is the generalised, timing-closable replacement for the 2-input, single-bit, purely combinational AND cell, intended for wide enable/qualifier trees in datapath and clock-gating control.

## Interface
- N_IN, 4, number of input vectors; legal 2..16
- WIDTH, 1, bits per vector; legal 1..64
- LVLS_PER_STAGE, 1, 2-input AND levels between registers; legal 1..4
- INVERT, 0, 1 = output is bitwise NAND of the reduction
- clk  input  1  single clock; all flops on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input vectors are valid this cycle
- a  input  N_IN*WIDTH  packed inputs; vector i = a[i*WIDTH +: WIDTH]
- out_valid  output  1  o is valid this cycle
- o  output  WIDTH  reduction result
- stall  input  1  present only with CTECH_LIB_AND_TREE_STALL_EN

## Operation
- Tree depth D = ceil(log2(N_IN)). Stage count S = ceil(D / LVLS_PER_STAGE). Latency L = S cycles.
- The tree is balanced binary. A level with an odd operand count passes the last operand through, equivalent to ANDing it with all-ones.
- Bit j of o is the AND over i of a[i][j], inverted if INVERT=1.
- Inversion is applied combinationally in front of the final stage register, never after it.
- Each stage registers its data and a valid bit. Data registers load every advancing cycle regardless of valid.
- out_valid is in_valid delayed by L. o is meaningful only while out_valid=1.
- Reset value of every flop is 0: out_valid=0 and o=0 in all modes, including INVERT=1.
- Reset mid-operation discards all in-flight samples. The first output after reset deassertion comes from a sample taken at or after the first rising edge following deassertion.
- No back-pressure without the macro: one sample may enter per cycle, so throughput is 1 sample per cycle.

## Timing
- in_valid and a are sampled at edge k. The result appears on o/out_valid after edge k+L-1 and is stable for cycle k+L.
- Examples: N_IN=2 gives D=1 and L=1. N_IN=16 with LVLS_PER_STAGE=1 gives L=4. N_IN=16 with LVLS_PER_STAGE=4 gives L=1. N_IN=5 with LVLS_PER_STAGE=2 gives D=3 and L=2.
- Outputs are driven directly from flops, with no combinational path from inputs to outputs.
- rst asserts outputs asynchronously, with no clock required. Deassertion must be synchronised by the integrator.

## Configuration
- CTECH_LIB_AND_TREE_STALL_EN defined:
  - adds the stall port;
  - while stall=1, every stage register (data and valid) holds its value, and in_valid/a are not sampled;
  - upstream must hold its sample until stall drops;
  - stall during rst has no effect.
- Macro undefined: no stall port, and the pipeline advances every cycle.

## Structure
- Package ctech_lib_and_tree_pkg holds:
  - functions tree_depth(n) and num_stages(n, lvls);
  - legal-range constants for the parameters;
  - an elaboration-time parameter check that triggers $fatal on illegal values.
- Sub-module ctech_lib_and_tree_stage implements one registered stage: M operands in, ceil(M/2^LVLS_PER_STAGE) operands out, plus the valid flop and the hold enable. The top instantiates it S times with a generate loop, and the last instance takes the INVERT option.

## Test plan
- Reset: hold rst=1 with random a/in_valid toggling, and INVERT=1 → out_valid=0 and o=0 throughout. Assert rst mid-stream → out_valid drops at once, with no stale result afterward.
- N_IN=4, WIDTH=8, LVLS_PER_STAGE=1: stream a={FF,F0,3C,FF} → o=30 with out_valid exactly 2 cycles after sampling; back-to-back samples give one result per cycle.
- N_IN=5, WIDTH=4, LVLS_PER_STAGE=2, INVERT=1: input {F,F,F,F,7} → o=8 at L=2. Input all F → o=0.
- Bubbles: in_valid pattern 1,0,1,1,0 → out_valid reproduces 1,0,1,1,0 delayed by L, with matching data order.
- STALL_EN, N_IN=16, L=4: inject 3 samples, assert stall for 5 cycles mid-flight → results hold, none lost or duplicated, and out_valid resumes exactly where it paused.
- Random sweep over all legal N_IN and LVLS_PER_STAGE with WIDTH=3: scoreboard against a reference AND model and the computed L.
